bank_stream_tx: RTL and testbench
=================================

# bank_stream_tx

Sequential transmitter for the s38584 select-bank path. It owns a 16-entry, 1-bit state bank and a 4-bit select code. On command, it streams the bank out one entry per accepted beat, together with the select code for that beat and a running XOR accumulator. It ends each frame with an even-parity beat. It is the producing end for the combinational select/XOR cone that consumes the select lines (`g5644`/`g5703`/`g5689`/`g5659` role) and the accumulator bit (`g5462` role). It sits in the sequential wrapper that re-registers converted s38584 cones.

## Interface
Parameters:
- `DEPTH`, default 16: bank entries. Must be a power of 2, at most 16.
- `AW`, default 4: select/address width; equals log2(`DEPTH`).

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `rst`: input, 1 bit. Reset is synchronous and active-high.
- `g35`: input, 1 bit. Global run enable. When 0, all state holds, except that bank writes are still accepted.
- `wr_valid`: input, 1 bit. Bank write request.
- `wr_ready`: output, 1 bit. Write accepted on a cycle where `wr_valid` and `wr_ready` are both 1.
- `wr_addr`: input, `AW` bits. Bank entry to write.
- `wr_data`: input, 1 bit. Bit to write.
- `start`: input, 1 bit. Single-cycle pulse; begins a frame.
- `busy`: output, 1 bit. 1 from frame acceptance until the parity beat is accepted.
- `tx_valid`: output, 1 bit. Beat present.
- `tx_ready`: input, 1 bit. Consumer accepts the beat.
- `tx_sel`: output, `AW` bits. Select code of the current beat.
- `tx_bit`: output, 1 bit. Bank bit for a data beat; parity bit on the last beat.
- `tx_acc`: output, 1 bit. XOR of all data bits accepted so far in this frame, excluding the current beat.
- `tx_last`: output, 1 bit. Marks the parity beat.

## Operation
States: IDLE, ARM, DATA, PARITY.

**IDLE**
- `wr_ready`=1.
- `start`=1 with `g35`=1 → ARM. The accumulator and the select counter both clear to 0.
- `start` while `g35`=0 is dropped.

**ARM**
- One cycle. Snapshots the bank into a shadow register, so later writes do not affect the in-flight frame.
- → DATA.

**DATA**
- `tx_valid`=1, `tx_sel`=cnt, `tx_bit`=shadow[cnt], `tx_last`=0.
- On a beat transfer: acc ^= `tx_bit`, and cnt increments.
- The transfer at cnt=`DEPTH`-1 → PARITY. cnt wraps to 0.

**PARITY**
- `tx_valid`=1, `tx_sel`=0, `tx_bit`=acc, `tx_acc`=acc, `tx_last`=1.
- Transfer → IDLE.

**Bank writes**
- `wr_ready`=1 in every state; the bank is never blocked.
- A write in the ARM cycle lands in the bank but not in the shadow.

**Enable and start handling**
- `g35`=0 in ARM/DATA/PARITY freezes the state, cnt and acc. `tx_valid` is forced to 0, and no transfer occurs.
- `start` while `busy` is ignored; no queueing.

**Output stability**
- `tx_*` outputs are registered and stable while `tx_valid`=1 and `tx_ready`=0.

## Timing
Reset values:
- State = IDLE, cnt = 0, acc = 0.
- Bank and shadow all 0.
- `tx_valid`=0, `tx_last`=0, `busy`=0, `wr_ready`=1.

Latencies:
- `start` to first `tx_valid` = 2 cycles (ARM, then DATA registered).
- Frame with `tx_ready` held high = `DEPTH`+1 consecutive beats, followed by 1 IDLE cycle before the next `start` is accepted.
- A write is visible to a frame only if accepted at least 1 cycle before the ARM cycle.

Simultaneous events and reset:
- A write to address k in the same cycle that cnt=k is transmitted: the transmitted value is the shadow value (old).
- `rst` mid-frame: the next cycle matches reset values. The bank clears and the frame is abandoned without a parity beat.

## Structure
- Shared package `s38584_pkg`:
  - State enum `tx_state_t`.
  - `AW`/`DEPTH` localparams.
  - Select-line bit positions mapping `tx_sel[3:0]` → `{g5659, g5689, g5703, g5644}`.
- One sub-module, `bank_shadow`: bank plus shadow register with write port, snapshot strobe and read mux.
- The FSM, counter and accumulator live in `bank_stream_tx`.

## Test plan
1. Reset, then write all 16 entries with pattern 0xA5C3 (bit i = entry i), then `start` with `tx_ready`=1 → beats with `tx_sel` 0..15 and bits matching the pattern. Parity beat: `tx_bit`=0 (8 ones), `tx_last`=1. Total 17 beats, `busy` falls after the last beat.
2. Same frame with `tx_ready` toggling 1,0,0,1 → stalled beats hold their values. Beat count is still 17, parity is unchanged.
3. During DATA at cnt=5, write entry 9 := ~old → transmitted bit 9 is the old value. The next frame shows the new value.
4. `g35`=0 for 3 cycles at cnt=7 → `tx_valid`=0 and cnt/acc frozen. Writes are accepted during the freeze. The frame resumes at cnt=7.
5. Bank = 0x0001 → `tx_acc` is 0 on beat 0 and 1 on beats 1..15. Parity bit = 1.
6. Assert `rst` at cnt=10 → the next cycle shows `tx_valid`=0, `busy`=0 and bank all 0. A new `start` emits 16 zeros plus parity 0.

Source files
------------

// File: rtl/s38584_pkg.sv
// -----------------------------------------------------------------------------
// s38584_pkg
// Shared definitions for the s38584 select-bank transmitter path.
//   - tx_state_t : frame sequencer states
//   - AW / DEPTH : default select width and bank depth
//   - SEL_G*     : bit positions of the consumer select lines inside tx_sel,
//                  tx_sel[3:0] -> {g5659, g5689, g5703, g5644}
// -----------------------------------------------------------------------------
package s38584_pkg;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_DATA   = 2'd2,
        ST_PARITY = 2'd3
    } tx_state_t;

    // Where each consumer select line sits inside tx_sel.
    localparam int SEL_G5644 = 0;
    localparam int SEL_G5703 = 1;
    localparam int SEL_G5689 = 2;
    localparam int SEL_G5659 = 3;

endpackage

// File: rtl/bank_stream_tx_bank_shadow.sv
// -----------------------------------------------------------------------------
// bank_shadow
// 1-bit state bank with a shadow copy. The bank takes writes at any time;
// the shadow is loaded from the whole bank on a snapshot strobe and is the
// only copy the transmitter reads, so in-flight frames are immune to writes.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (clears both copies)
//   wr_en/addr/data   : bank write port
//   snap              : load shadow from bank (bank value before this cycle's write)
//   rd_addr / rd_data : combinational read of the shadow
// -----------------------------------------------------------------------------
module bank_shadow #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_data,
    input  logic          snap,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_data
);

    logic [DEPTH-1:0] bank_q;
    logic [DEPTH-1:0] shadow_q;

    // NOTE: this storage is deliberately reset: a mid-frame reset must leave
    // the bank all-zero, so it is built from flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q   <= '0;
            shadow_q <= '0;
        end else begin
            // Both right-hand sides read pre-edge values, so a write in the
            // snapshot cycle reaches the bank but not the shadow.
            if (snap) begin
                shadow_q <= bank_q;
            end
            if (wr_en) begin
                bank_q[wr_addr] <= wr_data;
            end
        end
    end

    assign rd_data = shadow_q[rd_addr];

endmodule

// File: rtl/bank_stream_tx.sv
// -----------------------------------------------------------------------------
// bank_stream_tx
// Streams a snapshot of a 1-bit state bank as DEPTH data beats followed by one
// even-parity beat. Each data beat carries its select code and the running XOR
// of the data bits already accepted in the frame.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   g35                         : run enable; 0 freezes the frame (writes still land)
//   wr_valid/wr_ready/addr/data : bank write port, never back-pressured
//   start                       : one-cycle frame request (taken in IDLE only)
//   busy                        : frame accepted and parity beat not yet taken
//   tx_valid/tx_ready           : beat handshake
//   tx_sel/tx_bit/tx_acc/tx_last: beat payload
// -----------------------------------------------------------------------------
module bank_stream_tx #(
    parameter int DEPTH = s38584_pkg::DEPTH,
    parameter int AW    = s38584_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          g35,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_data,
    input  logic          start,
    output logic          busy,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [AW-1:0] tx_sel,
    output logic          tx_bit,
    output logic          tx_acc,
    output logic          tx_last
);
    import s38584_pkg::*;

    tx_state_t     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          acc_q, acc_d;
    logic          snap;
    logic          xfer;
    logic          shadow_bit;

    bank_shadow #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_valid & wr_ready),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .snap    (snap),
        .rd_addr (cnt_q),
        .rd_data (shadow_bit)
    );

    assign wr_ready = 1'b1;
    assign busy     = (state_q != ST_IDLE);
    // g35 gates valid directly so that a disabled cycle can never complete a
    // handshake; the payload itself comes only from registered state.
    assign tx_valid = g35 && (state_q == ST_DATA || state_q == ST_PARITY);
    assign xfer     = tx_valid && tx_ready;
    assign tx_acc   = acc_q;

    // NOTE: non-blocking assignments on every flop so all state updates see
    // the same pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        snap    = 1'b0;
        tx_sel  = '0;
        tx_bit  = 1'b0;
        tx_last = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && g35) begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
            end
            ST_ARM: begin
                if (g35) begin
                    snap    = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_sel = cnt_q;
                tx_bit = shadow_bit;
                if (xfer) begin
                    acc_d = acc_q ^ shadow_bit;
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_PARITY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                tx_bit  = acc_q;
                tx_last = 1'b1;
                if (xfer) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bank_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_bank_stream_tx
// Self-checking bench for bank_stream_tx. A frame-level model keeps its own
// copy of the bank and, when a frame is armed, precomputes the full list of
// 17 expected beats; the compare process walks that list as handshakes occur.
// Directed scenarios add literal expectations, then randomized frames follow.
// -----------------------------------------------------------------------------
module tb_bank_stream_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       g35 = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [3:0] wr_addr = '0;
    logic       wr_data = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [3:0] tx_sel;
    logic       tx_bit;
    logic       tx_acc;
    logic       tx_last;

    always #5 clk = ~clk;

    bank_stream_tx dut (
        .clk      (clk),
        .rst      (rst),
        .g35      (g35),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .busy     (busy),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_sel   (tx_sel),
        .tx_bit   (tx_bit),
        .tx_acc   (tx_acc),
        .tx_last  (tx_last)
    );

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    bit [15:0] mbank    = '0;
    bit        m_active = 1'b0;   // frame accepted, parity beat not yet taken
    bit        m_armed  = 1'b0;   // frame accepted, snapshot not yet taken
    int        m_idx    = 0;      // index of the beat currently offered
    bit [3:0]  f_sel [17];
    bit        f_bit [17];
    bit        f_acc [17];
    bit        f_last[17];
    bit        exp_valid;

    // Observed handshakes, kept as a ring indexed by a free-running count.
    int        obs_n = 0;
    bit [3:0]  obs_sel [64];
    bit        obs_bit [64];
    bit        obs_acc [64];
    bit        obs_last[64];

    task automatic build_frame(input bit [15:0] snap_bank);
        bit a;
        a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            f_sel[i]  = 4'(i);
            f_bit[i]  = snap_bank[i];
            f_acc[i]  = a;
            f_last[i] = 1'b0;
            a ^= snap_bank[i];
        end
        f_sel[16]  = 4'd0;
        f_bit[16]  = a;
        f_acc[16]  = a;
        f_last[16] = 1'b1;
    endtask

    // Mid-cycle: compare the current cycle, log handshakes, then advance the
    // model with the inputs that the coming rising edge will sample.
    always @(negedge clk) begin
        exp_valid = m_active && !m_armed && g35;
        if (cmp_en) begin
            check("tx_valid", 32'(tx_valid), 32'(exp_valid));
            check("busy", 32'(busy), 32'(m_active));
            check("wr_ready", 32'(wr_ready), 32'd1);
            if (exp_valid) begin
                check("tx_sel",  32'(tx_sel),  32'(f_sel[m_idx]));
                check("tx_bit",  32'(tx_bit),  32'(f_bit[m_idx]));
                check("tx_acc",  32'(tx_acc),  32'(f_acc[m_idx]));
                check("tx_last", 32'(tx_last), 32'(f_last[m_idx]));
            end
        end
        if (tx_valid && tx_ready) begin
            obs_sel[obs_n % 64]  = tx_sel;
            obs_bit[obs_n % 64]  = tx_bit;
            obs_acc[obs_n % 64]  = tx_acc;
            obs_last[obs_n % 64] = tx_last;
            obs_n++;
        end
        if (rst) begin
            mbank    = '0;
            m_active = 1'b0;
            m_armed  = 1'b0;
            m_idx    = 0;
        end else begin
            if (m_armed && g35) begin
                build_frame(mbank);
                m_armed = 1'b0;
            end else if (exp_valid && tx_ready) begin
                m_idx++;
                if (m_idx == 17) m_active = 1'b0;
            end else if (!m_active && start && g35) begin
                m_active = 1'b1;
                m_armed  = 1'b1;
                m_idx    = 0;
            end
            if (wr_valid) mbank[wr_addr] = wr_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pattern(input bit [15:0] p);
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 4'(i);
            wr_data  = p[i];
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 600; c++) begin
            if (!m_active) break;
            tick();
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_beat(input string name, input int k);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (m_active && !m_armed && m_idx == k) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check(name, 32'(found), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit [3:0] pat;
        bit any_one;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_last", 32'(tx_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        tick();

        // 1. Pattern 0xA5C3, ready held high.
        write_pattern(16'hA5C3);
        base = obs_n;
        pulse_start();
        check("t1_busy_arm", 32'(busy), 32'd1);
        wait_idle("t1_done");
        check("t1_beats", 32'(obs_n - base), 32'd17);
        check("t1_bit0", 32'(obs_bit[base % 64]), 32'd1);
        check("t1_bit2", 32'(obs_bit[(base + 2) % 64]), 32'd0);
        check("t1_sel15", 32'(obs_sel[(base + 15) % 64]), 32'd15);
        check("t1_parity", 32'(obs_bit[(base + 16) % 64]), 32'd0);
        check("t1_last", 32'(obs_last[(base + 16) % 64]), 32'd1);

        // 2. Same frame, ready pattern 1,0,0,1.
        tick();
        base = obs_n;
        pat = 4'b1001;
        pulse_start();
        for (int c = 0; c < 200 && m_active; c++) begin
            tx_ready = pat[c % 4];
            tick();
        end
        tx_ready = 1'b1;
        wait_idle("t2_done");
        check("t2_beats", 32'(obs_n - base), 32'd17);
        check("t2_parity", 32'(obs_bit[(base + 16) % 64]), 32'd0);

        // 3. Write entry 9 := ~old (old = 0) while cnt = 5.
        tick();
        base = obs_n;
        pulse_start();
        wait_beat("t3_at5", 5);
        wr_valid = 1'b1;
        wr_addr  = 4'd9;
        wr_data  = 1'b1;
        tick();
        wr_valid = 1'b0;
        wait_idle("t3_done");
        check("t3_old_bit9", 32'(obs_bit[(base + 9) % 64]), 32'd0);
        tick();
        base = obs_n;
        pulse_start();
        wait_idle("t3b_done");
        check("t3_new_bit9", 32'(obs_bit[(base + 9) % 64]), 32'd1);

        // 4. g35 low for 3 cycles at cnt = 7, write during the freeze.
        tick();
        base = obs_n;
        pulse_start();
        wait_beat("t4_at7", 7);
        g35 = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 4'd12;
        wr_data  = 1'b0;
        tick();
        wr_valid = 1'b0;
        tick();
        tick();
        g35 = 1'b1;
        @(negedge clk);
        check("t4_resume_valid", 32'(tx_valid), 32'd1);
        check("t4_resume_sel", 32'(tx_sel), 32'd7);
        tick();
        wait_idle("t4_done");
        check("t4_beats", 32'(obs_n - base), 32'd17);

        // 5. Bank = 0x0001.
        tick();
        write_pattern(16'h0001);
        base = obs_n;
        pulse_start();
        wait_idle("t5_done");
        check("t5_acc0", 32'(obs_acc[base % 64]), 32'd0);
        check("t5_acc1", 32'(obs_acc[(base + 1) % 64]), 32'd1);
        check("t5_acc15", 32'(obs_acc[(base + 15) % 64]), 32'd1);
        check("t5_parity", 32'(obs_bit[(base + 16) % 64]), 32'd1);

        // 6. Reset at cnt = 10, then a frame of zeros.
        tick();
        write_pattern(16'hFFFF);
        pulse_start();
        wait_beat("t6_at10", 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", 32'(tx_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        tick();
        base = obs_n;
        pulse_start();
        wait_idle("t6_done");
        any_one = 1'b0;
        for (int i = 0; i < 16; i++) any_one |= obs_bit[(base + i) % 64];
        check("t6_zero_bits", 32'(any_one), 32'd0);
        check("t6_parity", 32'(obs_bit[(base + 16) % 64]), 32'd0);
        check("t6_beats", 32'(obs_n - base), 32'd17);

        // Randomized frames: random bank, back-pressure, enable drops,
        // concurrent writes and stray start pulses.
        for (int f = 0; f < 6; f++) begin
            tick();
            write_pattern(16'($urandom));
            pulse_start();
            for (int c = 0; c < 400 && m_active; c++) begin
                tx_ready = ($urandom_range(0, 3) != 0);
                g35      = ($urandom_range(0, 9) != 0);
                wr_valid = ($urandom_range(0, 2) == 0);
                wr_addr  = 4'($urandom_range(0, 15));
                wr_data  = 1'($urandom_range(0, 1));
                start    = ($urandom_range(0, 7) == 0);
                tick();
            end
            tx_ready = 1'b1;
            g35      = 1'b1;
            wr_valid = 1'b0;
            start    = 1'b0;
            wait_idle("rand_done");
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
